mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/rr_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants, state type and index helpers for the three-requester
// memory port arbiter.
package mem_arb_pkg;

  localparam int NREQ = 3;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_LDST  = 2'd1;
  localparam logic [1:0] REQ_HOST  = 2'd2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Successor in the round-robin ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] k);
    return (k == REQ_HOST) ? REQ_FETCH : k + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [NREQ-1:0] oh);
    if (oh[2])
      return REQ_HOST;
    else if (oh[1])
      return REQ_LDST;
    else
      return REQ_FETCH;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 3-way round-robin picker: the first active request found
// searching upward from p (wrapping 2 -> 0) wins.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      p,
  output logic [NREQ-1:0] gnt
);

  logic [1:0] cand;

  always_comb begin
    gnt  = '0;
    cand = p;
    for (int i = 0; i < NREQ; i++) begin
      if ((gnt == '0) && req[cand])
        gnt[cand] = 1'b1;
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-cycle-latency memory port between
// fetch, load/store and host-loader requesters, with bounded grant locking.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [NREQ-1:0]   lock,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  // Counter value at which the grant in progress is the last one allowed.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  logic [1:0]      p_reg, p_next;
  arb_state_t      state_reg, state_next;
  logic [1:0]      owner_reg, owner_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [NREQ-1:0] rd_tag_reg, rd_tag_next;
  logic            rd_sel_reg, rd_sel_next;

  logic [NREQ-1:0] rr_gnt;
  logic [NREQ-1:0] gnt_int;
  logic [1:0]      gnt_idx;
  logic            locked_hold;

  rr_pick u_rr_pick (
    .req (req),
    .p   (p_reg),
    .gnt (rr_gnt)
  );

  always_comb begin
    locked_hold = (state_reg == LOCKED) && req[owner_reg];
    if (reset)
      gnt_int = '0;
    else if (locked_hold)
      gnt_int = NREQ'(1) << owner_reg;
    else
      gnt_int = rr_gnt;
    gnt_idx = onehot_idx(gnt_int);
  end

  assign gnt = gnt_int;

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (|gnt_int) begin
      unique case (gnt_idx)
        REQ_FETCH: begin
          mem_address = addr0;
          mem_data    = wdata0;
          mem_wren    = we[0];
        end
        REQ_LDST: begin
          mem_address = addr1;
          mem_data    = wdata1;
          mem_wren    = we[1];
        end
        REQ_HOST: begin
          mem_address = addr2;
          mem_data    = wdata2;
          mem_wren    = we[2];
        end
        default: ;
      endcase
    end
  end

  // Read return: the tag and select are one cycle behind the grant, and
  // reset masks anything still in flight.
  assign rvalid = reset ? '0 : rd_tag_reg;
  assign rdata  = (rd_sel_reg && !reset) ? mem_q : '0;

  always_comb begin
    p_next      = p_reg;
    state_next  = state_reg;
    owner_next  = owner_reg;
    cnt_next    = cnt_reg;
    rd_tag_next = '0;
    rd_sel_next = 1'b0;
    if (|gnt_int) begin
      // Every grant advances the pointer past k, so a lock exit finds it
      // already at (k+1) mod 3.
      p_next = rr_next(gnt_idx);
      if (!we[gnt_idx]) begin
        rd_tag_next = gnt_int;
        rd_sel_next = 1'b1;
      end
      if (locked_hold) begin
        if (!lock[owner_reg] || (cnt_reg >= LOCK_LAST)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end else if (lock[gnt_idx] && (LOCK_MAX > 1)) begin
        state_next = LOCKED;
        owner_next = gnt_idx;
        cnt_next   = CNT_W'(1);
      end else begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    end else if (state_reg == LOCKED) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_reg      <= REQ_FETCH;
      state_reg  <= IDLE;
      owner_reg  <= REQ_FETCH;
      cnt_reg    <= '0;
      rd_tag_reg <= '0;
      rd_sel_reg <= 1'b0;
    end else begin
      p_reg      <= p_next;
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      cnt_reg    <= cnt_next;
      rd_tag_reg <= rd_tag_next;
      rd_sel_reg <= rd_sel_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for reset, round-robin
// and idle behaviour, then hand sequences for write-read, lock and reset cases.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, we, lock;
  logic [7:0]  addr0, addr1, addr2;
  logic [31:0] wdata0, wdata1, wdata2;
  logic [2:0]  gnt, rvalid;
  logic [31:0] rdata, mem_data, mem_q;
  logic [7:0]  mem_address;
  logic        mem_wren;

  logic [31:0] mem [256];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [2:0]  lock;
    logic [2:0]  eg;
    logic [2:0]  erv;
    logic [31:0] erd;
    logic        ew;
    logic [7:0]  ea;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [14];

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .LOCK_MAX (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr0       (addr0),
    .addr1       (addr1),
    .addr2       (addr2),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .wdata2      (wdata2),
    .lock        (lock),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  // Synchronous single-port RAM with one cycle of read latency.
  always @(posedge clock) begin
    if (mem_wren)
      mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  initial begin
    for (int a = 0; a < 256; a++)
      mem[a] <= 32'hA000_0000 | 32'(a);
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic rst, input logic [2:0] r, w, l, eg, erv,
                              input logic [31:0] erd, input logic ew,
                              input logic [7:0] ea, input logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.req = r; v.we = w; v.lock = l;
    v.eg = eg; v.erv = erv; v.erd = erd; v.ew = ew; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] eg, erv, input logic [31:0] erd,
                     input logic ew, input logic [7:0] ea, input logic [31:0] ed);
    @(negedge clock);
    chk({tag, "/gnt"},    32'(gnt),         32'(eg));
    chk({tag, "/rvalid"}, 32'(rvalid),      32'(erv));
    chk({tag, "/rdata"},  rdata,            erd);
    chk({tag, "/wren"},   32'(mem_wren),    32'(ew));
    chk({tag, "/addr"},   32'(mem_address), 32'(ea));
    chk({tag, "/data"},   mem_data,         ed);
    $display("cycle %s req=%b we=%b lock=%b rst=%b gnt=%b rvalid=%b rdata=%h wren=%b addr=%h data=%h",
             tag, req, we, lock, reset, gnt, rvalid, rdata, mem_wren, mem_address, mem_data);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    req    = 3'b000;
    we     = 3'b000;
    lock   = 3'b000;
    addr0  = 8'h10;
    addr1  = 8'h21;
    addr2  = 8'h32;
    wdata0 = 32'h0000_00A0;
    wdata1 = 32'h0000_00B1;
    wdata2 = 32'h0000_00C2;

    // rst, req, we, lock | gnt, rvalid, rdata, wren, addr, data
    tbl[0]  = mk(1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0,         0, 8'h00, 32'h0);
    tbl[1]  = mk(1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0,         0, 8'h00, 32'h0);
    tbl[2]  = mk(0, 3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 32'h0,         0, 8'h10, 32'hA0);
    tbl[3]  = mk(0, 3'b111, 3'b000, 3'b000, 3'b010, 3'b001, 32'hA000_0010, 0, 8'h21, 32'hB1);
    tbl[4]  = mk(0, 3'b111, 3'b000, 3'b000, 3'b100, 3'b010, 32'hA000_0021, 0, 8'h32, 32'hC2);
    tbl[5]  = mk(0, 3'b111, 3'b000, 3'b000, 3'b001, 3'b100, 32'hA000_0032, 0, 8'h10, 32'hA0);
    tbl[6]  = mk(0, 3'b111, 3'b000, 3'b000, 3'b010, 3'b001, 32'hA000_0010, 0, 8'h21, 32'hB1);
    tbl[7]  = mk(0, 3'b111, 3'b000, 3'b000, 3'b100, 3'b010, 32'hA000_0021, 0, 8'h32, 32'hC2);
    tbl[8]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 32'hA000_0032, 0, 8'h00, 32'h0);
    tbl[9]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0,         0, 8'h00, 32'h0);
    tbl[10] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0,         0, 8'h00, 32'h0);
    tbl[11] = mk(0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 32'h0,         0, 8'h21, 32'hB1);
    tbl[12] = mk(0, 3'b111, 3'b000, 3'b000, 3'b100, 3'b010, 32'hA000_0021, 0, 8'h32, 32'hC2);
    tbl[13] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 32'hA000_0032, 0, 8'h00, 32'h0);

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst;
      req   = tbl[i].req;
      we    = tbl[i].we;
      lock  = tbl[i].lock;
      cyc($sformatf("t%0d", i), tbl[i].eg, tbl[i].erv, tbl[i].erd,
          tbl[i].ew, tbl[i].ea, tbl[i].ed);
    end

    // Write then read of the same address on consecutive cycles.
    addr1 = 8'h05; wdata1 = 32'hDEAD_BEEF; req = 3'b010; we = 3'b010;
    cyc("wr_a5", 3'b010, 3'b000, 32'h0, 1'b1, 8'h05, 32'hDEAD_BEEF);
    addr0 = 8'h05; req = 3'b001; we = 3'b000;
    cyc("rd_a5", 3'b001, 3'b000, 32'h0, 1'b0, 8'h05, 32'hA0);
    req = 3'b000;
    cyc("rd_a5_ret", 3'b000, 3'b001, 32'hDEAD_BEEF, 1'b0, 8'h00, 32'h0);
    addr0 = 8'h10; addr1 = 8'h21; wdata1 = 32'h0000_00B1;

    // Lock on requester 2 limited to four grants, then fair rotation.
    req = 3'b010;
    cyc("lk_pre", 3'b010, 3'b000, 32'h0, 1'b0, 8'h21, 32'hB1);
    req = 3'b111; lock = 3'b100;
    cyc("lk1", 3'b100, 3'b010, 32'hA000_0021, 1'b0, 8'h32, 32'hC2);
    cyc("lk2", 3'b100, 3'b100, 32'hA000_0032, 1'b0, 8'h32, 32'hC2);
    cyc("lk3", 3'b100, 3'b100, 32'hA000_0032, 1'b0, 8'h32, 32'hC2);
    cyc("lk4", 3'b100, 3'b100, 32'hA000_0032, 1'b0, 8'h32, 32'hC2);
    cyc("lk5", 3'b001, 3'b100, 32'hA000_0032, 1'b0, 8'h10, 32'hA0);
    cyc("lk6", 3'b010, 3'b001, 32'hA000_0010, 1'b0, 8'h21, 32'hB1);
    cyc("lk7", 3'b100, 3'b010, 32'hA000_0021, 1'b0, 8'h32, 32'hC2);
    req = 3'b000; lock = 3'b000;
    cyc("lk_end", 3'b000, 3'b100, 32'hA000_0032, 1'b0, 8'h00, 32'h0);

    // Read in flight when reset arrives must be dropped; pointer restarts at 0.
    req = 3'b010;
    cyc("rs_rd", 3'b010, 3'b000, 32'h0, 1'b0, 8'h21, 32'hB1);
    reset = 1'b1; req = 3'b111;
    cyc("rs_on", 3'b000, 3'b000, 32'h0, 1'b0, 8'h00, 32'h0);
    reset = 1'b0; req = 3'b000;
    cyc("rs_off", 3'b000, 3'b000, 32'h0, 1'b0, 8'h00, 32'h0);
    req = 3'b111;
    cyc("rs_p0", 3'b001, 3'b000, 32'h0, 1'b0, 8'h10, 32'hA0);
    req = 3'b000;
    cyc("rs_ret", 3'b000, 3'b001, 32'hA000_0010, 1'b0, 8'h00, 32'h0);

    // Requester 0 withdraws before winning; it must never be granted.
    req = 3'b011;
    cyc("dr1", 3'b010, 3'b000, 32'h0, 1'b0, 8'h21, 32'hB1);
    req = 3'b010;
    cyc("dr2", 3'b010, 3'b010, 32'hA000_0021, 1'b0, 8'h21, 32'hB1);
    req = 3'b000;
    cyc("dr3", 3'b000, 3'b010, 32'hA000_0021, 1'b0, 8'h00, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
